// File: rtl/clk_freq_monitor.sv
//==============================================================================
// Module      : clk_freq_monitor
// Description : Multi-channel clock frequency monitor. Counts synchronized
//               divider ticks over a programmable ext_clk window and flags
//               out-of-tolerance channels. Optional macro CLK_MON_STICKY_EN
//               makes freq_err sticky until err_clr.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module clk_freq_monitor #(
    parameter int NUM_CH     = 2,
    parameter int CNT_W      = 16,
    parameter int MISS_LIMIT = 3
) (
    input  logic                    ext_clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [NUM_CH-1:0]       tick_in,
    input  logic [CNT_W-1:0]        cfg_win,
    input  logic [NUM_CH*CNT_W-1:0] cfg_exp_cnt,
    input  logic [CNT_W-1:0]        cfg_tol,
    input  logic                    err_clr,
    output logic [NUM_CH*CNT_W-1:0] meas_cnt,
    output logic                    meas_done,
    output logic [NUM_CH-1:0]       freq_err,
    output logic [NUM_CH-1:0]       alarm
);

    localparam int                  c_STRK_W   = $clog2(MISS_LIMIT + 1);
    localparam logic [c_STRK_W-1:0] c_STRK_MAX = c_STRK_W'(MISS_LIMIT);
    localparam logic [CNT_W-1:0]    c_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0]    c_CNT_MAX  = {CNT_W{1'b1}};

    localparam logic [1:0] c_S_IDLE    = 2'd0;
    localparam logic [1:0] c_S_MEASURE = 2'd1;
    localparam logic [1:0] c_S_COMPARE = 2'd2;

    logic [1:0]              r_state;
    logic [1:0]              w_state_next;
    logic                    w_start;
    logic                    w_update;
    logic                    w_win_last;
    logic [CNT_W-1:0]        r_win_len;
    logic [CNT_W-1:0]        r_win_cnt;
    logic [CNT_W-1:0]        r_tol;
    logic [NUM_CH*CNT_W-1:0] r_exp;
    logic                    r_meas_done;

`ifndef CLK_MON_STICKY_EN
    logic w_unused_err_clr;
    assign w_unused_err_clr = err_clr;
`endif

    assign w_win_last = (r_win_cnt == (r_win_len - c_ONE));
    assign meas_done  = r_meas_done;

    always_ff @(posedge ext_clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_update     = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (enable) begin
                    w_state_next = c_S_MEASURE;
                    w_start      = 1'b1;
                end
            end
            c_S_MEASURE: begin
                if (!enable) begin
                    w_state_next = c_S_IDLE;
                end else if (w_win_last) begin
                    w_state_next = c_S_COMPARE;
                end
            end
            c_S_COMPARE: begin
                w_update = 1'b1;
                if (enable) begin
                    w_state_next = c_S_MEASURE;
                    w_start      = 1'b1;
                end else begin
                    w_state_next = c_S_IDLE;
                end
            end
            default: w_state_next = c_S_IDLE;
        endcase
    end

    // Window configuration is snapshotted at window start so mid-window
    // register writes never corrupt a measurement in flight.
    always_ff @(posedge ext_clk) begin
        if (reset) begin
            r_win_len   <= '0;
            r_win_cnt   <= '0;
            r_tol       <= '0;
            r_exp       <= '0;
            r_meas_done <= 1'b0;
        end else begin
            r_meas_done <= w_update;
            if (w_start) begin
                r_win_cnt <= '0;
                r_win_len <= (cfg_win == '0) ? c_ONE : cfg_win;
                r_exp     <= cfg_exp_cnt;
                r_tol     <= cfg_tol;
            end else if (r_state == c_S_MEASURE) begin
                r_win_cnt <= r_win_cnt + c_ONE;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic                r_sync1;
        logic                r_sync2;
        logic                r_hist;
        logic                w_edge;
        logic [CNT_W-1:0]    r_edge_cnt;
        logic [CNT_W-1:0]    r_meas;
        logic [CNT_W-1:0]    w_exp;
        logic [CNT_W:0]      w_lo;
        logic [CNT_W:0]      w_hi;
        logic                w_win_err;
        logic [c_STRK_W-1:0] r_streak;
        logic                r_err;

        assign w_edge = r_sync2 & ~r_hist;
        assign w_exp  = r_exp[g*CNT_W +: CNT_W];
        // One extra bit keeps exp+tol from wrapping near full scale.
        assign w_lo      = (w_exp >= r_tol) ? {1'b0, w_exp - r_tol} : '0;
        assign w_hi      = {1'b0, w_exp} + {1'b0, r_tol};
        assign w_win_err = ({1'b0, r_edge_cnt} < w_lo) || ({1'b0, r_edge_cnt} > w_hi);

        assign meas_cnt[g*CNT_W +: CNT_W] = r_meas;
        assign freq_err[g]                = r_err;
        assign alarm[g]                   = (r_streak == c_STRK_MAX);

        always_ff @(posedge ext_clk) begin
            if (reset) begin
                r_sync1    <= 1'b0;
                r_sync2    <= 1'b0;
                r_hist     <= 1'b0;
                r_edge_cnt <= '0;
            end else begin
                r_sync1 <= tick_in[g];
                r_sync2 <= r_sync1;
                r_hist  <= r_sync2;
                if (w_start) begin
                    r_edge_cnt <= '0;
                end else if ((r_state == c_S_MEASURE) && w_edge && (r_edge_cnt != c_CNT_MAX)) begin
                    r_edge_cnt <= r_edge_cnt + c_ONE;
                end
            end
        end

        always_ff @(posedge ext_clk) begin
            if (reset) begin
                r_meas   <= '0;
                r_streak <= '0;
            end else if (w_update) begin
                r_meas <= r_edge_cnt;
                if (!w_win_err) begin
                    r_streak <= '0;
                end else if (r_streak != c_STRK_MAX) begin
                    r_streak <= r_streak + c_STRK_W'(1);
                end
            end
        end

`ifdef CLK_MON_STICKY_EN
        // A freshly failing window wins over a coincident err_clr.
        always_ff @(posedge ext_clk) begin
            if (reset) begin
                r_err <= 1'b0;
            end else if (w_update && w_win_err) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
`else
        always_ff @(posedge ext_clk) begin
            if (reset) begin
                r_err <= 1'b0;
            end else if (w_update) begin
                r_err <= w_win_err;
            end
        end
`endif
    end

endmodule

`default_nettype wire

// File: doc/clk_freq_monitor.md
CLK_FREQ_MONITOR -- requirements
Module: clk_freq_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of monitored channels.
REQ-002 SHALL have parameter CNT_W, default 16, width of edge and window counters.
REQ-003 SHALL have parameter MISS_LIMIT, default 3, consecutive failing windows before alarm.
REQ-004 SHALL have port ext_clk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  in  1  run measurement windows while high.
REQ-007 SHALL have port tick_in  in  NUM_CH  per-channel toggle from a divider in the monitored domain (asynchronous).
REQ-008 SHALL have port cfg_win  in  CNT_W  window length in ext_clk cycles.
REQ-009 SHALL have port cfg_exp_cnt  in  NUM_CH*CNT_W  expected edges per window, channel 0 in the LSBs.
REQ-010 SHALL have port cfg_tol  in  CNT_W  allowed deviation, shared by all channels.
REQ-011 SHALL have port err_clr  in  1  clear pulse for error flags.
REQ-012 SHALL have port meas_cnt  out  NUM_CH*CNT_W  edge counts from the last completed window.
REQ-013 SHALL have port meas_done  out  1  one-cycle pulse when meas_cnt/freq_err update.
REQ-014 SHALL have port freq_err  out  NUM_CH  per-channel out-of-tolerance flag.
REQ-015 SHALL have port alarm  out  NUM_CH  per-channel alarm for persistent failure.

Function
REQ-016 SHALL pass each tick_in bit through a 2-flop synchronizer plus a third history flop, and count an edge on each synchronized rising edge only.
REQ-017 SHALL implement FSM IDLE, MEASURE, COMPARE.
REQ-018 SHALL go IDLE->MEASURE on the cycle after enable=1, clearing the window and edge counters.
REQ-019 SHALL latch cfg_win, cfg_exp_cnt, cfg_tol on entry to MEASURE and ignore changes to them until the next window.
REQ-020 SHALL stay in MEASURE for exactly max(cfg_win,1) cycles, then enter COMPARE for one cycle.
REQ-021 SHALL saturate each edge counter at 2^CNT_W-1 with no wrap.
REQ-022 SHALL ignore edges in the COMPARE cycle.
REQ-023 SHALL, in COMPARE, load meas_cnt, evaluate errors, and assert meas_done on the following cycle, then go to MEASURE if enable=1, else IDLE.
REQ-024 SHALL flag a window error when count < lo or count > hi, where lo = exp-tol floored at 0 and hi = exp+tol computed in CNT_W+1 bits.
REQ-025 SHALL keep, per channel, a failing-window streak counter saturating at MISS_LIMIT, reset to 0 by a passing window.
REQ-026 SHALL assert alarm[ch] while the streak equals MISS_LIMIT; a passing window deasserts it.
REQ-027 SHALL, when enable=0 during MEASURE, return to IDLE next cycle, discard partial counts, emit no meas_done, and leave meas_cnt, freq_err, alarm and streaks unchanged.
REQ-028 SHALL, when err_clr coincides with an update, give the update priority for the channels it sets.

Reset
REQ-029 SHALL, on reset=1 at a clock edge, drive FSM=IDLE and clear all synchronizer flops, counters, streaks, meas_cnt, meas_done, freq_err and alarm to 0.
REQ-030 SHALL let reset take priority over every other input, including a mid-window reset.

Configuration
REQ-031 SHALL, with macro CLK_MON_STICKY_EN defined, OR freq_err[ch] with each new window error, holding it until err_clr=1 (clears it next cycle).
REQ-032 SHALL, without CLK_MON_STICKY_EN, replace freq_err with the latest window's result on each update and ignore err_clr; alarm is unaffected by the macro.

Verification
REQ-033 SHALL pass this check: NUM_CH=2, cfg_win=100, exp=10/10, tol=1, tick_in[0] toggles every 5 cycles -> meas_cnt[0] is 9..11, freq_err[0]=0, meas_done every 101 cycles.
REQ-034 SHALL pass this check: tick_in[1] held at 0, exp[1]=10, tol=1 -> meas_cnt[1]=0, freq_err[1]=1 each window, alarm[1]=1 after the 3rd window.
REQ-035 SHALL pass this check: channel 1 resumes toggling every 5 cycles after the alarm -> first passing window clears alarm[1]; with STICKY freq_err[1] stays 1 until err_clr, without it drops to 0.
REQ-036 SHALL pass this check: exp=3, tol=5 (floor case) with 0 edges -> no error; exp=0xFFFF, tol=2, CNT_W=16 -> no overflow, saturated count 0xFFFF passes.
REQ-037 SHALL pass this check: enable dropped at cycle 50 of a 100-cycle window -> no meas_done, outputs unchanged; re-enable -> a full 100-cycle window follows.
REQ-038 SHALL pass this check: reset asserted mid-window with alarm=1 -> next cycle all outputs 0 and FSM in IDLE.
